// File: rtl/r_cpu_pkg.sv
// Shared definitions for the R-format CPU controller: FSM states, ALU op codes,
// opcode and funct values.
package r_cpu_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_WB   = 3'd3,
      S_HALT = 3'd4
   } state_t;

   localparam logic [5:0] OPC_RTYPE = 6'h00;

   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_SLLV = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_ADDU = 4'd9;
   localparam logic [ALU_OP_W-1:0] ALU_SUBU = 4'd10;

endpackage

// File: rtl/r_cpu_decode.sv
// Combinational R-format decoder: opcode/funct to ALU op code and legality.
// Unsupported encodings give ALU op 0 with legal low.
module r_cpu_decode
   import r_cpu_pkg::*;
(
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                legal
);

   always_comb begin
      alu_op = ALU_AND;
      legal  = (opcode == OPC_RTYPE);
      case (funct)
         FN_ADD:  alu_op = ALU_ADD;
         FN_ADDU: alu_op = ALU_ADDU;
         FN_SUB:  alu_op = ALU_SUB;
         FN_SUBU: alu_op = ALU_SUBU;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_XOR:  alu_op = ALU_XOR;
         FN_NOR:  alu_op = ALU_NOR;
         FN_SLT:  alu_op = ALU_SLT;
         FN_SLTU: alu_op = ALU_SLTU;
         FN_SLLV: alu_op = ALU_SLLV;
         default: legal  = 1'b0;
      endcase
      if (!legal)
         alu_op = ALU_AND;
   end

endmodule

// File: rtl/r_cpu_ctrl.sv
// Multi-cycle IF/ID/EX/WB controller with retired-instruction counter.
// R_CTRL_ILLEGAL_TRAP_EN: halt on illegal instruction instead of treating it as a NOP.
module r_cpu_ctrl #(
   parameter int RET_CNT_W = 16,
   parameter int ALU_OP_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          ir,
   input  logic                 imem_rdy,
   output logic                 imem_req,
   output logic                 ir_we,
   output logic                 ab_we,
   output logic                 f_we,
   output logic                 flag_we,
   output logic                 rf_we,
   output logic                 pc_we,
   output logic [ALU_OP_W-1:0]  alu_op,
   output logic                 illegal,
   output logic [RET_CNT_W-1:0] retired
);
   import r_cpu_pkg::*;

   // state  | meaning
   // S_IF   | fetch request, wait for imem_rdy, load IR
   // S_ID   | latch A/B operands
   // S_EX   | ALU op valid, latch F and flags
   // S_WB   | register write (rd != 0), PC+4, retire
   // S_HALT | trapped on illegal instruction, exit only by rst

   state_t                        r_state, w_next;
   logic [RET_CNT_W-1:0]          r_retired;
   logic                          r_illegal;
   logic [r_cpu_pkg::ALU_OP_W-1:0] w_dec_alu;
   logic                          w_legal;
   logic                          w_rd_nz;
   logic                          w_retire, w_set_ill;
   logic                          w_req, w_ir_we, w_ab_we, w_f_we, w_flag_we, w_rf_we, w_pc_we;
   logic [ALU_OP_W-1:0]           w_alu;
   logic                          w_unused;

   assign w_rd_nz  = (ir[15:11] != 5'd0);
   assign w_unused = ^{ir[25:16], ir[10:6]};

   r_cpu_decode u_decode (
      .opcode (ir[31:26]),
      .funct  (ir[5:0]),
      .alu_op (w_dec_alu),
      .legal  (w_legal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IF;
         r_retired <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_retire)
            r_retired <= r_retired + RET_CNT_W'(1);
         if (w_set_ill)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_req     = 1'b0;
      w_ir_we   = 1'b0;
      w_ab_we   = 1'b0;
      w_f_we    = 1'b0;
      w_flag_we = 1'b0;
      w_rf_we   = 1'b0;
      w_pc_we   = 1'b0;
      w_alu     = '0;
      w_retire  = 1'b0;
      w_set_ill = 1'b0;
      case (r_state)
         S_IF: begin
            w_req = 1'b1;
            if (imem_rdy) begin
               w_ir_we = 1'b1;
               w_next  = S_ID;
            end
         end
         S_ID: begin
            w_ab_we = 1'b1;
            w_next  = S_EX;
         end
         S_EX: begin
            w_alu     = ALU_OP_W'(w_dec_alu);
            w_f_we    = 1'b1;
            w_flag_we = 1'b1;
            w_next    = S_WB;
         end
         S_WB: begin
            w_set_ill = ~w_legal;
`ifdef R_CTRL_ILLEGAL_TRAP_EN
            if (w_legal) begin
               w_pc_we  = 1'b1;
               w_rf_we  = w_rd_nz;
               w_retire = 1'b1;
               w_next   = S_IF;
            end else begin
               w_next = S_HALT;
            end
`else
            w_pc_we  = 1'b1;
            w_rf_we  = w_legal & w_rd_nz;
            w_retire = 1'b1;
            w_next   = S_IF;
`endif
         end
         S_HALT: w_next = S_HALT;
         default: w_next = S_IF;
      endcase
   end

   // Reset gates every output combinationally, so an aborted WB never writes.
   assign imem_req = w_req & ~rst;
   assign ir_we    = w_ir_we & ~rst;
   assign ab_we    = w_ab_we & ~rst;
   assign f_we     = w_f_we & ~rst;
   assign flag_we  = w_flag_we & ~rst;
   assign rf_we    = w_rf_we & ~rst;
   assign pc_we    = w_pc_we & ~rst;
   assign alu_op   = rst ? '0 : w_alu;
   assign illegal  = r_illegal & ~rst;
   assign retired  = rst ? '0 : r_retired;

endmodule

// File: tb/tb_r_cpu_ctrl.sv
// Self-checking bench for r_cpu_ctrl: directed and random instructions checked
// cycle by cycle against an instruction-level reference model.
module tb_r_cpu_ctrl;

   localparam int RW = 4;

   localparam logic [6:0] E_REQ  = 7'b1000000;
   localparam logic [6:0] E_IRWE = 7'b0100000;
   localparam logic [6:0] E_AB   = 7'b0010000;
   localparam logic [6:0] E_FFL  = 7'b0001100;
   localparam logic [6:0] E_RF   = 7'b0000010;
   localparam logic [6:0] E_PC   = 7'b0000001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   ir = '0;
   logic          imem_rdy = 1'b0;
   logic          imem_req, ir_we, ab_we, f_we, flag_we, rf_we, pc_we, illegal;
   logic [3:0]    alu_op;
   logic [RW-1:0] retired;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int m_ret  = 0;
   bit m_ill  = 1'b0;

`ifdef R_CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   r_cpu_ctrl #(.RET_CNT_W(RW), .ALU_OP_W(4)) dut (
      .clk(clk), .rst(rst), .ir(ir), .imem_rdy(imem_rdy),
      .imem_req(imem_req), .ir_we(ir_we), .ab_we(ab_we), .f_we(f_we),
      .flag_we(flag_we), .rf_we(rf_we), .pc_we(pc_we), .alu_op(alu_op),
      .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic bit ref_legal(input logic [31:0] v);
      logic [5:0] fn;
      fn = v[5:0];
      if (v[31:26] != 6'd0) return 1'b0;
      return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                        6'h26, 6'h27, 6'h2A, 6'h2B, 6'h04};
   endfunction

   function automatic logic [3:0] ref_alu(input logic [31:0] v);
      if (!ref_legal(v)) return 4'd0;
      case (v[5:0])
         6'h24: return 4'd0;
         6'h25: return 4'd1;
         6'h26: return 4'd2;
         6'h27: return 4'd3;
         6'h20: return 4'd4;
         6'h22: return 4'd5;
         6'h2A: return 4'd6;
         6'h2B: return 4'd7;
         6'h04: return 4'd8;
         6'h21: return 4'd9;
         6'h23: return 4'd10;
         default: return 4'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs are already driven; sample mid-cycle, then advance past the next edge.
   task automatic cyc(input string tag, input logic [6:0] es, input logic [3:0] ea,
                      input bit eill, input int eret);
      @(negedge clk);
      chk({tag, "/strobes"}, {25'd0, imem_req, ir_we, ab_we, f_we, flag_we, rf_we, pc_we},
          {25'd0, es});
      chk({tag, "/alu_op"}, {28'd0, alu_op}, {28'd0, ea});
      chk({tag, "/illegal"}, {31'd0, illegal}, {31'd0, eill});
      chk({tag, "/retired"}, {28'd0, retired}, eret);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         ir       = $urandom;
         imem_rdy = 1'($urandom_range(0, 1));
         cyc("reset", 7'd0, 4'd0, 1'b0, 0);
      end
      rst   = 1'b0;
      m_ret = 0;
      m_ill = 1'b0;
   endtask

   // One instruction: `stalls` cycles with imem_rdy low, then fetch, ID, EX, WB.
   // abort >= 0 pulses rst on that cycle of the instruction.
   task automatic run_instr(input string tag, input logic [31:0] v, input int stalls,
                            input int abort);
      bit         lg;
      logic [3:0] ea;
      logic [6:0] es;
      lg = ref_legal(v);
      ea = ref_alu(v);
      ir = v;
      for (int c = 0; c < stalls + 4; c++) begin
         if (c < stalls)       imem_rdy = 1'b0;
         else if (c == stalls) imem_rdy = 1'b1;
         else                  imem_rdy = 1'($urandom_range(0, 1));
         if (c == abort) begin
            rst = 1'b1;
            cyc({tag, "/abort"}, 7'd0, 4'd0, 1'b0, 0);
            rst   = 1'b0;
            m_ret = 0;
            m_ill = 1'b0;
            return;
         end
         if (c < stalls)           es = E_REQ;
         else if (c == stalls)     es = E_REQ | E_IRWE;
         else if (c == stalls + 1) es = E_AB;
         else if (c == stalls + 2) es = E_FFL;
         else if (lg)              es = E_PC | ((v[15:11] != 5'd0) ? E_RF : 7'd0);
         else                      es = TRAP ? 7'd0 : E_PC;
         cyc(tag, es, (c == stalls + 2) ? ea : 4'd0, m_ill, m_ret);
      end
      if (!lg) m_ill = 1'b1;
      if (lg || !TRAP) m_ret = (m_ret + 1) % (1 << RW);
      if (!lg && TRAP) begin
         for (int h = 0; h < 10; h++) begin
            imem_rdy = 1'($urandom_range(0, 1));
            cyc({tag, "/halt"}, 7'd0, 4'd0, 1'b1, m_ret);
         end
         do_reset(1);
      end
   endtask

   function automatic logic [31:0] rand_instr(input bit force_legal);
      logic [5:0] fl [11];
      logic [5:0] op, fn;
      fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h04};
      op = (force_legal || $urandom_range(0, 7) != 0) ? 6'd0 : 6'($urandom);
      fn = (force_legal || $urandom_range(0, 4) != 0) ? fl[$urandom_range(0, 10)]
                                                       : 6'($urandom);
      return {op, 10'($urandom), 5'($urandom_range(0, 3)), 5'($urandom), fn};
   endfunction

   initial begin
      @(posedge clk);
      #1;
      do_reset(2);
      run_instr("add", 32'h00221820, 0, -1);
      run_instr("sub_stall", 32'h00221822, 3, -1);
      run_instr("add_r0", 32'h00220020, 0, -1);
      run_instr("abort_ex", 32'h00221820, 0, 2);
      run_instr("after_abort", 32'h00221824, 0, -1);
      run_instr("abort_wb", 32'h00221825, 0, 3);
      run_instr("abort_stall", 32'h00221826, 3, 1);
      run_instr("or", 32'h00221825, 1, -1);
      run_instr("lw", 32'h8C010000, 0, -1);
      run_instr("post_lw", 32'h0022182A, 0, -1);
      run_instr("bad_funct", 32'h0022183F, 2, -1);
      do_reset(1);
      for (int i = 0; i < 17; i++)
         run_instr("wrap", rand_instr(1'b1), 0, -1);
      for (int i = 0; i < 40; i++)
         run_instr("rand", rand_instr(1'b0), $urandom_range(0, 3), -1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/r_cpu_ctrl.md
R_CPU_CTRL -- requirements
Module: r_cpu_ctrl

Interface
REQ-001 SHALL have parameter RET_CNT_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have parameter ALU_OP_W, default 4, width of alu_op.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ir, input, 32, datapath instruction register contents (MIPS R-format).
REQ-006 SHALL have port imem_rdy, input, 1, instruction memory data valid this cycle.
REQ-007 SHALL have port imem_req, output, 1, fetch request.
REQ-008 SHALL have ports ir_we, ab_we, f_we, flag_we, rf_we, pc_we, output, 1 each: load IR; latch A/B operands; latch ALU result F; latch ZF/OF; regfile write of rd; PC<=PC+4.
REQ-009 SHALL have port alu_op, output, ALU_OP_W, ALU operation code.
REQ-010 SHALL have port illegal, output, 1, sticky unsupported-instruction flag.
REQ-011 SHALL have port retired, output, RET_CNT_W, count of completed instructions.

Function
REQ-012 SHALL implement Moore FSM S_IF, S_ID, S_EX, S_WB, S_HALT; strobes decoded from state register and ir.
REQ-013 S_IF: imem_req=1; on imem_rdy=1 pulse ir_we same cycle, next S_ID; else stay S_IF (no timeout).
REQ-014 S_ID: ab_we=1 one cycle; next S_EX.
REQ-015 S_EX: alu_op valid, f_we=1, flag_we=1 one cycle; next S_WB.
REQ-016 S_WB: pc_we=1; rf_we=1 only if instruction legal and ir[15:11]!=0; retired increments by 1, wraps modulo 2^RET_CNT_W; next S_IF.
REQ-017 Instruction latency SHALL be 4 cycles when imem_rdy is high on first S_IF cycle, +1 per stalled S_IF cycle.
REQ-018 Legal iff ir[31:26]=0 and funct in {0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x04 SLLV}.
REQ-019 alu_op encoding: AND 0, OR 1, XOR 2, NOR 3, ADD 4, SUB 5, SLT 6, SLTU 7, SLLV 8, ADDU 9, SUBU 10; illegal -> 0 with f_we/flag_we still pulsed.
REQ-020 All strobes SHALL be 0 outside the states listed; never two states' strobes simultaneously.
REQ-021 Illegal handling SHALL follow REQ-030.

Reset
REQ-022 While rst=1 all outputs SHALL be 0 (strobes gated), including imem_req.
REQ-023 Rising edge with rst=1: state<=S_IF, retired<=0, illegal<=0.
REQ-024 rst in any state, including mid-stall or S_WB, SHALL abort the instruction: no rf_we/pc_we that cycle, no retire.
REQ-025 First cycle after rst deasserts SHALL be S_IF with imem_req=1.

Configuration
REQ-026 Macro R_CTRL_ILLEGAL_TRAP_EN selects illegal-instruction policy.
REQ-027 Defined: illegal instruction in S_WB sets illegal=1, no rf_we, no pc_we, no retire, next S_HALT; S_HALT holds, all strobes 0, exits only by rst.
REQ-028 Undefined: illegal instruction executes as NOP: pc_we=1, rf_we=0, retired increments; illegal still set sticky; S_HALT unreachable.
REQ-029 Legal-instruction behaviour identical in both builds.
REQ-030 illegal SHALL clear only on rst.

Structure
REQ-031 Shared package r_cpu_pkg SHALL hold state encoding, ALU_OP_W, alu_op constants, opcode/funct constants.
REQ-032 One sub-module r_cpu_decode (combinational funct->alu_op, legal) SHALL be instantiated; FSM and counter stay in r_cpu_ctrl.

Verification
REQ-033 rst 2 cycles, imem_rdy=1, ir=0x00221820 (add $3,$1,$2) -> strobes ir_we,ab_we,f_we+flag_we,rf_we+pc_we on cycles 1-4, alu_op=4, retired=1.
REQ-034 ir=0x00221822 (sub), imem_rdy low 3 cycles -> imem_req held 4 cycles, ir_we only on rdy cycle, alu_op=5, total 7 cycles.
REQ-035 ir=0x00220020 (add $0) -> rf_we never 1, pc_we=1, retired+1.
REQ-036 ir=0x8C010000 (lw): with macro -> illegal=1, S_HALT, no further pc_we over 10 cycles; without -> pc_we=1, rf_we=0, retired+1, illegal=1.
REQ-037 rst asserted in S_EX -> next cycle all outputs 0, then S_IF, retired=0.
REQ-038 RET_CNT_W=4, 16 legal instructions -> retired wraps 15->0.
